// File: rtl/cic_seq_pkg.sv
// Shared constants and types for the CIC DSP48 integrator sequencer.
package cic_seq_pkg;

    // Slice operation select, as seen on the opcode output
    localparam logic OP_ACC = 1'b0;   // P <= P + concat
    localparam logic OP_CLR = 1'b1;   // P <= 0

    // Slice timing: concat in cycle t lands in P on edge t+4,
    // and the opcode for that data trails it by one cycle.
    localparam int SLICE_DATA_LAT = 4;
    localparam int SLICE_OP_LAG   = 1;

    // Number of clear cycles used to flush P after reset/restart
    localparam int INIT_CYCLES = 5;

    // Width of the A:B operand bus into the slice
    localparam int SLICE_W = 48;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_CLEAR = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cic_seq_delay.sv
// Fixed-depth shift line carrying per-beat tags alongside the slice pipeline.
module cic_seq_delay
    import cic_seq_pkg::*;
#(
    parameter int DEPTH = SLICE_DATA_LAT,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] line;

    // Shift one stage per cycle; clr flushes every stage at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (clr) begin
            line <= '0;
        end else begin
            line[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign dout = line[DEPTH-1];

endmodule

// File: rtl/cic_dsp48_sequencer.sv
// Drives an external DSP48 slice as an M-sample integrate-and-dump
// accumulator: feeds samples on concat, issues a clear between frames,
// and captures the frame sum from P when the last beat has drained through.
module cic_dsp48_sequencer
    import cic_seq_pkg::*;
#(
    parameter int IW = 5,
    parameter int M  = 256,
    parameter int OW = IW + $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [IW-1:0] s_data,
    output logic [47:0]   concat,
    output logic          opcode,
    input  logic [47:0]   p,
    output logic          m_valid,
    output logic [OW-1:0] m_data
);

    // Beat counter only needs to reach M-1; keep at least one bit for M=1
    localparam int CNT_W  = (M > 1) ? $clog2(M) : 1;
    localparam int INIT_W = $clog2(INIT_CYCLES);

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(M - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    seq_state_t                state;
    seq_state_t                state_nxt;
    logic [CNT_W-1:0]          count;
    logic [INIT_W-1:0]         init_cnt;
    logic                      accept;
    logic                      last_beat;
    logic                      op_now;
    logic                      tag_out;
    logic [SLICE_OP_LAG-1:0]   op_lag;

    // Upper P bits are never needed: OW is sized for the full-scale sum
    logic unused_p;
    assign unused_p = ^p;

    // Restart wins over a beat in the same cycle, so it also drops ready
    assign s_ready   = (state == ST_ACCUM) && !restart;
    assign accept    = s_valid && s_ready;
    assign last_beat = accept && (count == LAST_CNT);

    // Idle ACCUM cycles add zero, so P just holds
    assign concat = accept ? {{(SLICE_W - IW){s_data[IW-1]}}, s_data} : '0;

    // Only a live ACCUM cycle accumulates; INIT, CLEAR and restart clear
    assign op_now = (state == ST_ACCUM && !restart) ? OP_ACC : OP_CLR;

    // Next-state selection; restart returns to INIT from anywhere
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = ST_INIT;
        end else begin
            unique case (state)
                ST_INIT:  if (init_cnt == INIT_LAST) state_nxt = ST_ACCUM;
                ST_ACCUM: if (last_beat)             state_nxt = ST_CLEAR;
                ST_CLEAR: state_nxt = ST_ACCUM;
                default:  state_nxt = ST_INIT;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    // Counts INIT cycles; held at zero outside INIT so every entry starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (restart || state != ST_INIT || init_cnt == INIT_LAST) begin
            init_cnt <= '0;
        end else begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Beats accepted in the current frame; wraps on the M-th beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (accept) begin
            count <= last_beat ? '0 : count + 1'b1;
        end
    end

    // Opcode trails the data it applies to by the slice's opcode lag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_lag <= {SLICE_OP_LAG{OP_CLR}};
        end else begin
            op_lag[0] <= op_now;
            for (int i = 1; i < SLICE_OP_LAG; i++) begin
                op_lag[i] <= op_lag[i-1];
            end
        end
    end

    assign opcode = op_lag[SLICE_OP_LAG-1];

    // Last-beat flag rides alongside the data; it emerges the cycle P holds the sum
    cic_seq_delay #(
        .DEPTH (SLICE_DATA_LAT),
        .WIDTH (1)
    ) u_tag (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .din  (last_beat),
        .dout (tag_out)
    );

    // Capture the frame sum when its last-flag drains; restart drops it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            m_valid <= tag_out && !restart;
            if (tag_out && !restart) begin
                m_data <= p[OW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_cic_dsp48_sequencer.sv
// Bench: three sequencers (M=4, M=256, M=1) each driving a behavioural
// DSP48 integrator slice; a per-cycle scoreboard checks them against
// frame sums computed from the accepted samples.
module tb_cic_dsp48_sequencer;

    localparam int IW = 5;
    localparam int MV[3] = '{4, 256, 1};
    localparam int INITC = 5;

    logic clk = 1'b0;
    logic rst;
    logic restart[3];
    logic s_valid[3];
    logic s_ready[3];
    logic signed [IW-1:0] s_data[3];
    logic [47:0] concat[3];
    logic opcode[3];
    logic m_valid[3];
    logic [6:0]  md0;
    logic [12:0] md1;
    logic [4:0]  md2;

    // Slice model registers (no reset, like the real slice)
    logic [47:0] p[3]  = '{default: 48'h0000_0BAD_0000};
    logic [47:0] d1[3] = '{default: 48'd0};
    logic [47:0] d2[3] = '{default: 48'd0};
    logic [47:0] d3[3] = '{default: 48'd0};
    logic        o1[3] = '{default: 1'b0};
    logic        o2[3] = '{default: 1'b0};

    typedef struct { int k; int due; longint val; } exp_t;
    typedef struct { int k; int cyc; longint val; } obs_t;
    exp_t   expq[$];
    obs_t   obs[$];
    int     blk[3];
    int     cnt[3];
    longint sum[3];
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    cic_dsp48_sequencer #(.IW(IW), .M(4)) u_m4 (
        .clk(clk), .rst(rst), .restart(restart[0]), .s_valid(s_valid[0]),
        .s_ready(s_ready[0]), .s_data(s_data[0]), .concat(concat[0]),
        .opcode(opcode[0]), .p(p[0]), .m_valid(m_valid[0]), .m_data(md0));

    cic_dsp48_sequencer #(.IW(IW), .M(256)) u_m256 (
        .clk(clk), .rst(rst), .restart(restart[1]), .s_valid(s_valid[1]),
        .s_ready(s_ready[1]), .s_data(s_data[1]), .concat(concat[1]),
        .opcode(opcode[1]), .p(p[1]), .m_valid(m_valid[1]), .m_data(md1));

    cic_dsp48_sequencer #(.IW(IW), .M(1)) u_m1 (
        .clk(clk), .rst(rst), .restart(restart[2]), .s_valid(s_valid[2]),
        .s_ready(s_ready[2]), .s_data(s_data[2]), .concat(concat[2]),
        .opcode(opcode[2]), .p(p[2]), .m_valid(m_valid[2]), .m_data(md2));

    always #5 clk = ~clk;

    // Slice: concat registered three times, opcode twice, then P update
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            d1[k] <= concat[k];
            d2[k] <= d1[k];
            d3[k] <= d2[k];
            o1[k] <= opcode[k];
            o2[k] <= o1[k];
            p[k]  <= o2[k] ? 48'd0 : p[k] + d3[k];
        end
    end

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int n_obs(input int k, input int from);
        int n = 0;
        for (int i = from; i < obs.size(); i++) if (obs[i].k == k) n++;
        return n;
    endfunction

    // Scoreboard: runs at the falling edge, checks this cycle's outputs and
    // advances the model to what the coming rising edge does.
    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            logic signed [63:0] md;
            logic        exp_rdy, acc, hit;
            longint      hit_val;
            logic [47:0] exp_cat;
            md = (k == 0) ? 64'($signed(md0)) : (k == 1) ? 64'($signed(md1)) : 64'($signed(md2));
            if (m_valid[k] === 1'b1) obs.push_back('{k, cyc, md});
            if (rst) begin
                chk($sformatf("rst_ready%0d", k), s_ready[k], 0);
                chk($sformatf("rst_mvalid%0d", k), m_valid[k], 0);
                chk($sformatf("rst_mdata%0d", k), md, 0);
                chk($sformatf("rst_concat%0d", k), concat[k], 0);
                chk($sformatf("rst_opcode%0d", k), opcode[k], 1);
                for (int i = expq.size() - 1; i >= 0; i--) if (expq[i].k == k) expq.delete(i);
                blk[k] = INITC; cnt[k] = 0; sum[k] = 0;
            end else begin
                exp_rdy = (blk[k] == 0) && !restart[k];
                acc     = exp_rdy && s_valid[k];
                exp_cat = acc ? 48'($signed(s_data[k])) : 48'd0;
                chk($sformatf("ready%0d", k), s_ready[k], exp_rdy);
                chk($sformatf("concat%0d", k), concat[k], exp_cat);
                hit = 1'b0; hit_val = 0;
                foreach (expq[i]) if (expq[i].k == k && expq[i].due == cyc) begin
                    hit = 1'b1; hit_val = expq[i].val;
                end
                chk($sformatf("mvalid%0d", k), m_valid[k], hit);
                if (hit && m_valid[k] === 1'b1) chk($sformatf("mdata%0d", k), md, hit_val);
                for (int i = expq.size() - 1; i >= 0; i--)
                    if (expq[i].k == k && (restart[k] || expq[i].due <= cyc)) expq.delete(i);
                if (restart[k]) begin
                    blk[k] = INITC; cnt[k] = 0; sum[k] = 0;
                end else begin
                    if (blk[k] > 0) blk[k]--;
                    if (acc) begin
                        sum[k] += s_data[k];
                        cnt[k]++;
                        if (cnt[k] == MV[k]) begin
                            expq.push_back('{k, cyc + 5, sum[k]});
                            cnt[k] = 0; sum[k] = 0; blk[k] = 1;
                        end
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, o0, n, acc, waits, bud;
        int bv[4];
        int dv[2];
        int dc[2];
        bv = '{3, -1, 2, 5};
        dv = '{7, -2};
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            restart[k] = 1'b0; s_valid[k] = 1'b0; s_data[k] = '0;
        end
        // M=256 instance streams -16 for the whole run
        s_valid[1] = 1'b1; s_data[1] = -5'sd16;
        repeat (3) step();
        chk("rst_lit_md0", md0, 0);
        chk("rst_lit_op0", opcode[0], 1);
        rst = 1'b0;

        // Continuous ones into M=4: sums of 4 every 5 cycles
        c0 = cyc; o0 = obs.size();
        s_valid[0] = 1'b1; s_data[0] = 5'sd1;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) chk("A_ready_init_end", s_ready[0], 0);
            if (i == 5) chk("A_ready_rise", s_ready[0], 1);
            step();
        end
        s_valid[0] = 1'b0;
        repeat (8) step();
        n = 0;
        for (int i = o0; i < obs.size(); i++) if (obs[i].k == 0) begin
            if (n == 0) chk("A_first_at", obs[i].cyc - c0, 13);
            if (n == 1) chk("A_second_at", obs[i].cyc - c0, 18);
            chk("A_sum", obs[i].val, 4);
            n++;
        end
        chk("A_count", n, 3);

        // Gapped samples 3,-1,2,5 with junk on the bus while idle
        o0 = obs.size();
        for (int i = 0; i < 4; i++) begin
            s_valid[0] = 1'b1; s_data[0] = 5'(bv[i]);
            step();
            s_valid[0] = 1'b0; s_data[0] = -5'sd7;
            repeat (2) step();
        end
        repeat (8) step();
        chk("B_count", n_obs(0, o0), 1);
        for (int i = o0; i < obs.size(); i++) if (obs[i].k == 0) chk("B_sum", obs[i].val, 9);

        // Two beats, restart, then a fresh frame of four ones
        o0 = obs.size();
        s_valid[0] = 1'b1; s_data[0] = 5'sd1;
        repeat (2) step();
        s_valid[0] = 1'b0; restart[0] = 1'b1;
        step();
        restart[0] = 1'b0; s_valid[0] = 1'b1;
        acc = 0; waits = 0; bud = 0;
        while (acc < 4 && bud < 50) begin
            if (s_ready[0] === 1'b1) acc++;
            else if (acc == 0) waits++;
            step();
            bud++;
        end
        s_valid[0] = 1'b0;
        chk("C_init_wait", waits, 5);
        chk("C_beats", acc, 4);
        repeat (8) step();
        chk("C_count", n_obs(0, o0), 1);
        for (int i = o0; i < obs.size(); i++) if (obs[i].k == 0) chk("C_sum", obs[i].val, 4);

        // M=1: each sample is its own frame, ready toggles
        o0 = obs.size();
        for (int i = 0; i < 2; i++) begin
            s_valid[2] = 1'b1; s_data[2] = 5'(dv[i]);
            bud = 0;
            while (s_ready[2] !== 1'b1 && bud < 10) begin step(); bud++; end
            chk("D_ready_wait", bud < 10, 1);
            step();
            chk("D_ready_low", s_ready[2], 0);
        end
        s_valid[2] = 1'b0;
        step();
        chk("D_ready_high", s_ready[2], 1);
        repeat (8) step();
        n = 0;
        for (int i = o0; i < obs.size(); i++) if (obs[i].k == 2) begin
            if (n < 2) begin
                chk("D_sum", obs[i].val, dv[n]);
                dc[n] = obs[i].cyc;
            end
            n++;
        end
        chk("D_count", n, 2);
        if (n == 2) chk("D_spacing", dc[1] - dc[0], 2);

        // Asynchronous reset mid-frame, then a clean frame
        s_valid[0] = 1'b1; s_data[0] = 5'sd2;
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        chk("E_async_md0", md0, 0);
        chk("E_async_md2", md2, 0);
        chk("E_async_mv0", m_valid[0], 0);
        chk("E_async_rdy0", s_ready[0], 0);
        chk("E_async_rdy1", s_ready[1], 0);
        chk("E_async_cat1", concat[1], 0);
        chk("E_async_op0", opcode[0], 1);
        step();
        s_data[0] = 5'sd1;
        step();
        rst = 1'b0;
        c0 = cyc; o0 = obs.size();
        repeat (14) step();
        s_valid[0] = 1'b0;
        repeat (8) step();
        n = 0;
        for (int i = o0; i < obs.size(); i++) if (obs[i].k == 0) begin
            if (n == 0) chk("E_first_at", obs[i].cyc - c0, 13);
            chk("E_sum", obs[i].val, 4);
            n++;
        end
        chk("E_count", n, 2);

        // M=256 of -16 each frame: -4096, the most negative 13-bit value
        bud = 0;
        while (n_obs(1, o0) < 2 && bud < 1500) begin step(); bud++; end
        chk("F_frames", n_obs(1, o0) >= 2, 1);
        for (int i = o0; i < obs.size(); i++) if (obs[i].k == 1) chk("F_sum", obs[i].val, -4096);
        chk("F_mdata_hex", md1, 13'h1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
